// File: rtl/nonrestoring_divider_pkg.sv
// Shared constants and FSM encoding for the 16/8 non-restoring divider.
// Operand widths and the state type are defined once here and imported by every file.
package nonrestoring_divider_pkg;

   localparam int BUS_WIDTH_DEF = 8;
   localparam int CNT_BITS_DEF  = 3;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LD_AH,
      S_LD_QL,
      S_CHECK,
      S_ITER,
      S_CORR,
      S_OUT_REM,
      S_OUT_QUO,
      S_ERR
   } div_state_e;

endpackage

// File: rtl/nonrestoring_divider_if.sv
// Shared operand/result bus: operand bytes in, registered result bytes out.
// The requester drives the master side; the divider is the slave.
interface nonrestoring_divider_if
   import nonrestoring_divider_pkg::*;
#(
   parameter int BUS_WIDTH = BUS_WIDTH_DEF
) ();

   logic [BUS_WIDTH-1:0] inbus;
   logic                 beginsig;
   logic                 locksig;
   logic [BUS_WIDTH-1:0] outbus;
   logic                 endsig;
   logic                 errsig;

   modport master (output inbus, beginsig, locksig, input outbus, endsig, errsig);
   modport slave  (input inbus, beginsig, locksig, output outbus, endsig, errsig);

endinterface

// File: rtl/nonrestoring_divider_div_control_unit.sv
// Divider sequencer: load, guard check, BUS_WIDTH iterations, correction, result dump.
// Fixed 14-edge latency (4 on error); no backpressure, begin is only looked at in IDLE.
module div_control_unit
   import nonrestoring_divider_pkg::*;
#(
   parameter int BUS_WIDTH = BUS_WIDTH_DEF,
   parameter int CNT_BITS  = CNT_BITS_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic beginsig,
   input  logic locksig,
   input  logic a_sign,
   input  logic div_err,
   output logic ld_m,
   output logic ld_a,
   output logic ld_q,
   output logic iter_sub,
   output logic iter_add,
   output logic corr_add,
   output logic dump_rem,
   output logic dump_quo,
   output logic dump_err
);

   localparam logic [CNT_BITS-1:0] LAST_ITER = CNT_BITS'(BUS_WIDTH - 1);

   div_state_e          state_q, state_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ld_m     = 1'b0;
      ld_a     = 1'b0;
      ld_q     = 1'b0;
      iter_sub = 1'b0;
      iter_add = 1'b0;
      corr_add = 1'b0;
      dump_rem = 1'b0;
      dump_quo = 1'b0;
      dump_err = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (beginsig && locksig) begin
               ld_m    = 1'b1;
               state_d = S_LD_AH;
            end
         end
         // Losing the bus mid-load abandons the request silently.
         S_LD_AH: begin
            if (locksig) begin
               ld_a    = 1'b1;
               state_d = S_LD_QL;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LD_QL: begin
            if (locksig) begin
               ld_q    = 1'b1;
               state_d = S_CHECK;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CHECK: begin
            if (div_err) begin
               state_d = S_ERR;
            end else begin
               cnt_d   = '0;
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            iter_sub = !a_sign;
            iter_add = a_sign;
            if (cnt_q == LAST_ITER) begin
               state_d = S_CORR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // Correction and remainder dump share one edge so the remainder lands on outbus directly.
         S_CORR: begin
            corr_add = a_sign;
            dump_rem = 1'b1;
            state_d  = S_OUT_REM;
         end
         S_OUT_REM: begin
            dump_quo = 1'b1;
            state_d  = S_OUT_QUO;
         end
         S_OUT_QUO: state_d = S_IDLE;
         S_ERR: begin
            dump_err = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: rtl/nonrestoring_divider.sv
// Unsigned 2N/N non-restoring divider datapath (M, 9-bit signed A, Q) on the shared byte bus.
// Remainder after E12, quotient+endsig after E13, error after E4; no backpressure.
module nonrestoring_divider
   import nonrestoring_divider_pkg::*;
#(
   parameter int BUS_WIDTH = BUS_WIDTH_DEF,
   parameter int CNT_BITS  = CNT_BITS_DEF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   nonrestoring_divider_if.slave  bus
);

   localparam int AW = BUS_WIDTH + 1;

   logic [BUS_WIDTH-1:0] m_q, m_d;
   logic [AW-1:0]        a_q, a_d;
   logic [BUS_WIDTH-1:0] q_q, q_d;
   logic [BUS_WIDTH-1:0] outbus_q, outbus_d;
   logic                 endsig_q, endsig_d;
   logic                 errsig_q, errsig_d;

   logic ld_m, ld_a, ld_q, iter_sub, iter_add, corr_add, dump_rem, dump_quo, dump_err;
   logic div_err;

   logic [AW-1:0] m_ext, a_shift, a_new, a_corr;

   div_control_unit #(
      .BUS_WIDTH (BUS_WIDTH),
      .CNT_BITS  (CNT_BITS)
   ) u_ctrl (
      .clk      (clk),
      .reset_n  (reset_n),
      .beginsig (bus.beginsig),
      .locksig  (bus.locksig),
      .a_sign   (a_q[AW-1]),
      .div_err  (div_err),
      .ld_m     (ld_m),
      .ld_a     (ld_a),
      .ld_q     (ld_q),
      .iter_sub (iter_sub),
      .iter_add (iter_add),
      .corr_add (corr_add),
      .dump_rem (dump_rem),
      .dump_quo (dump_quo),
      .dump_err (dump_err)
   );

   // A high byte >= M would give a quotient wider than BUS_WIDTH.
   assign div_err = (m_q == '0) || (a_q[BUS_WIDTH-1:0] >= m_q);

   assign m_ext   = {1'b0, m_q};
   assign a_shift = {a_q[BUS_WIDTH-1:0], q_q[BUS_WIDTH-1]};
   assign a_new   = iter_sub ? (a_shift - m_ext) : (a_shift + m_ext);
   assign a_corr  = corr_add ? (a_q + m_ext) : a_q;

   always_comb begin
      m_d      = m_q;
      a_d      = a_q;
      q_d      = q_q;
      outbus_d = '0;
      endsig_d = 1'b0;
      errsig_d = 1'b0;
      if (ld_m) m_d = bus.inbus;
      if (ld_a) a_d = {1'b0, bus.inbus};
      if (ld_q) q_d = bus.inbus;
      if (iter_sub || iter_add) begin
         a_d = a_new;
         q_d = {q_q[BUS_WIDTH-2:0], ~a_new[AW-1]};
      end
      if (corr_add) a_d = a_corr;
      if (dump_rem) outbus_d = a_corr[BUS_WIDTH-1:0];
      if (dump_quo) begin
         outbus_d = q_q;
         endsig_d = 1'b1;
      end
      if (dump_err) begin
         endsig_d = 1'b1;
         errsig_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_q      <= '0;
         a_q      <= '0;
         q_q      <= '0;
         outbus_q <= '0;
         endsig_q <= 1'b0;
         errsig_q <= 1'b0;
      end else begin
         m_q      <= m_d;
         a_q      <= a_d;
         q_q      <= q_d;
         outbus_q <= outbus_d;
         endsig_q <= endsig_d;
         errsig_q <= errsig_d;
      end
   end

   assign bus.outbus = outbus_q;
   assign bus.endsig = endsig_q;
   assign bus.errsig = errsig_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed vector bench for nonrestoring_divider: table of divisions plus abort/reset/noise sequences.
module tb_nonrestoring_divider;

   typedef struct packed {
      logic [7:0] m;
      logic [7:0] ah;
      logic [7:0] ql;
      logic       err;
      logic [7:0] rem;
      logic [7:0] quo;
   } vec_t;

   localparam int NVEC = 9;

   logic clk;
   logic reset_n;
   int   checks;
   int   failures;
   vec_t vecs [NVEC];

   nonrestoring_divider_if #(.BUS_WIDTH(8)) bus ();

   nonrestoring_divider #(
      .BUS_WIDTH (8),
      .CNT_BITS  (3)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [9:0] outs();
      return {bus.endsig, bus.errsig, bus.outbus};
   endfunction

   // mode: 0 clean, 1 begin/lock noise during ITER, 2 async reset after quotient, 3 async reset in 4th ITER cycle
   task automatic run_op(input vec_t v, input int mode);
      logic bad;
      bad = 1'b0;
      bus.inbus    = v.m;
      bus.beginsig = 1'b1;
      bus.locksig  = 1'b1;
      @(posedge clk); #1;
      bus.beginsig = 1'b0;
      bus.inbus    = v.ah;
      @(posedge clk); #1;
      bus.inbus    = v.ql;
      @(posedge clk); #1;
      bus.locksig  = 1'b0;
      bus.inbus    = '0;
      if (mode == 1) begin
         bus.beginsig = 1'b1;
         bus.locksig  = 1'b1;
         bus.inbus    = 8'hAA;
      end
      for (int e = 3; e <= 14; e++) begin
         @(posedge clk); #1;
         if (mode == 1 && e == 10) begin
            bus.beginsig = 1'b0;
            bus.locksig  = 1'b0;
            bus.inbus    = '0;
         end
         if (v.err) begin
            if (e == 3)      chk("err_not_early", 32'(outs()), 32'h0);
            else if (e == 4) chk("err_flag", 32'(outs()), 32'h300);
            else if (bus.endsig || bus.errsig) bad = 1'b1;
         end else if (mode == 3) begin
            if (e == 6) begin
               reset_n = 1'b0;
               #1;
               chk("rst_iter_outs", 32'(outs()), 32'h0);
               #2;
               reset_n = 1'b1;
            end else if (e > 6 && (outs() != 10'h0)) begin
               bad = 1'b1;
            end
         end else begin
            if (e < 12) begin
               if (bus.endsig || bus.errsig) bad = 1'b1;
            end else if (e == 12) begin
               chk("remainder", 32'(outs()), 32'({2'b00, v.rem}));
            end else if (e == 13) begin
               chk("quotient", 32'(outs()), 32'({2'b10, v.quo}));
               if (mode == 2) begin
                  reset_n = 1'b0;
                  #1;
                  chk("rst_async_outs", 32'(outs()), 32'h0);
                  #1;
                  reset_n = 1'b1;
               end
            end else begin
               chk("back_idle", 32'(outs()), 32'h0);
            end
         end
      end
      chk("no_stray_end", 32'(bad), 32'h0);
   endtask

   // at_edge 1 drops locksig on the LD_AH edge, 2 on the LD_QL edge
   task automatic abort_op(input int at_edge);
      logic bad;
      bad = 1'b0;
      bus.inbus    = 8'h07;
      bus.beginsig = 1'b1;
      bus.locksig  = 1'b1;
      @(posedge clk); #1;
      bus.beginsig = 1'b0;
      bus.inbus    = 8'h00;
      if (at_edge == 1) bus.locksig = 1'b0;
      @(posedge clk); #1;
      bus.inbus    = 8'h64;
      bus.locksig  = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(posedge clk); #1;
         if (bus.endsig || bus.errsig || bus.outbus != 8'h00) bad = 1'b1;
      end
      bus.inbus = '0;
      chk("abort_silent", 32'(bad), 32'h0);
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      reset_n      = 1'b1;
      bus.inbus    = '0;
      bus.beginsig = 1'b0;
      bus.locksig  = 1'b0;

      vecs[0] = '{m: 8'h07, ah: 8'h00, ql: 8'h64, err: 1'b0, rem: 8'h02, quo: 8'h0E};
      vecs[1] = '{m: 8'h56, ah: 8'h12, ql: 8'h34, err: 1'b0, rem: 8'h10, quo: 8'h36};
      vecs[2] = '{m: 8'hFF, ah: 8'hFE, ql: 8'hFF, err: 1'b0, rem: 8'hFE, quo: 8'hFF};
      vecs[3] = '{m: 8'h00, ah: 8'h12, ql: 8'h34, err: 1'b1, rem: 8'h00, quo: 8'h00};
      vecs[4] = '{m: 8'h07, ah: 8'h07, ql: 8'h00, err: 1'b1, rem: 8'h00, quo: 8'h00};
      vecs[5] = '{m: 8'h01, ah: 8'h00, ql: 8'h01, err: 1'b0, rem: 8'h00, quo: 8'h01};
      vecs[6] = '{m: 8'h10, ah: 8'h00, ql: 8'hFF, err: 1'b0, rem: 8'h0F, quo: 8'h0F};
      vecs[7] = '{m: 8'h07, ah: 8'h06, ql: 8'hFF, err: 1'b0, rem: 8'h06, quo: 8'hFF};
      vecs[8] = '{m: 8'h80, ah: 8'h7F, ql: 8'h80, err: 1'b0, rem: 8'h00, quo: 8'hFF};

      #2 reset_n = 1'b0;
      bus.beginsig = 1'b1;
      bus.locksig  = 1'b1;
      bus.inbus    = 8'h07;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outbus", 32'(bus.outbus), 32'h0);
      chk("reset_endsig", 32'(bus.endsig), 32'h0);
      chk("reset_errsig", 32'(bus.errsig), 32'h0);
      bus.beginsig = 1'b0;
      bus.locksig  = 1'b0;
      bus.inbus    = '0;
      #2 reset_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < NVEC; i++) run_op(vecs[i], 0);

      run_op(vecs[1], 1);
      abort_op(2);
      run_op(vecs[0], 0);
      abort_op(1);
      run_op(vecs[0], 0);
      run_op(vecs[0], 3);
      run_op(vecs[0], 0);
      run_op(vecs[2], 2);
      run_op(vecs[1], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
